// File: rtl/core_pkg.sv
// Shared RV32I core constants: datapath width, architectural register count and the zero register.
package core_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned REG_AW    = $clog2(NREGS_DEF);
  localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for hazard detection: issue sets, writeback clears, and issue wins on a tie.
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NRD*AW-1:0]    raddr,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [NRD-1:0]       rbusy,
  output logic [NREGS-1:0]     busy_vec
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] set_c, clr_c;
  logic [AW-1:0]    ra;

  // Set/clear vectors for this cycle; the zero register can never become busy.
  always_comb begin
    set_c = '0;
    clr_c = '0;
    if (iss_valid && (iss_rd != AW'(REG_ZERO))) set_c[iss_rd] = 1'b1;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (we[k] && (waddr[k*AW +: AW] != AW'(REG_ZERO))) clr_c[waddr[k*AW +: AW]] = 1'b1;
    end
    busy_d           = (busy_q & ~clr_c) | set_c;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  // A same-cycle writeback releases the reader early unless a new producer issues to the same register.
  always_comb begin
    rbusy = '0;
    ra    = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      ra       = raddr[j*AW +: AW];
      rbusy[j] = busy_q[ra] && (ra != AW'(REG_ZERO));
      if (BYPASS && clr_c[ra] && !set_c[ra]) rbusy[j] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0, prioritised writes, optional write-to-read bypass and busy scoreboard.
module regfile_mp
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [NREGS-1:0]     busy_vec
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [AW-1:0]              ra;
  logic [XLEN-1:0]            rv;

  // Ascending port order lets the highest-index enabled port win a same-address collision.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (we[k] && (waddr[k*AW +: AW] != AW'(REG_ZERO))) begin
        regs_d[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
      end
    end
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Reads are forced to zero during reset so a pending write cannot bypass through.
  always_comb begin
    rdata = '0;
    ra    = '0;
    rv    = '0;
    for (int unsigned j = 0; j < NRD; j++) begin
      ra = raddr[j*AW +: AW];
      rv = regs_q[ra];
      if (BYPASS) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (we[k] && (waddr[k*AW +: AW] == ra)) rv = wdata[k*XLEN +: XLEN];
        end
      end
      if ((ra == AW'(REG_ZERO)) || !rst_n) rv = '0;
      rdata[j*XLEN +: XLEN] = rv;
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .raddr     (raddr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rbusy     (rbusy),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus and are checked against an array model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic        iss_valid;
  logic [4:0]  iss_rd;

  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [31:0] busy_b, busy_n;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .rbusy(rbusy_b), .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_b)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_n), .rbusy(rbusy_n), .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] we_v, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic iv, input logic [4:0] ird);
    we = we_v; waddr = {wa1, wa0}; wdata = {wd1, wd0};
    raddr = {ra1, ra0}; iss_valid = iv; iss_rd = ird;
  endtask

  function automatic bit written_now(input int a);
    for (int k = 0; k < 2; k++)
      if (we[k] && (int'(waddr[k*5 +: 5]) == a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd(input int a, input bit byp);
    if (!rst_n || a == 0) return 32'h0;
    if (byp) begin
      for (int k = 1; k >= 0; k--)
        if (we[k] && (int'(waddr[k*5 +: 5]) == a)) return wdata[k*32 +: 32];
    end
    return m_reg[a];
  endfunction

  function automatic bit exp_rbusy(input int a, input bit byp);
    if (!rst_n || a == 0 || !m_busy[a]) return 1'b0;
    if (byp && written_now(a) && !(iss_valid && int'(iss_rd) == a)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = rst_n ? m_busy[i] : 1'b0;
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Checks combinational outputs of both instances, then advances one edge and updates the model.
  task automatic step();
    int a;
    if (!rst_n) clear_model();
    #1;
    for (int j = 0; j < 2; j++) begin
      a = int'(raddr[j*5 +: 5]);
      check($sformatf("rdata_byp[%0d] x%0d", j, a), 64'(rdata_b[j*32 +: 32]), 64'(exp_rd(a, 1'b1)));
      check($sformatf("rdata_nobyp[%0d] x%0d", j, a), 64'(rdata_n[j*32 +: 32]), 64'(exp_rd(a, 1'b0)));
      check($sformatf("rbusy_byp[%0d] x%0d", j, a), 64'(rbusy_b[j]), 64'(exp_rbusy(a, 1'b1)));
      check($sformatf("rbusy_nobyp[%0d] x%0d", j, a), 64'(rbusy_n[j]), 64'(exp_rbusy(a, 1'b0)));
    end
    check("busy_vec_byp", 64'(busy_b), 64'(exp_vec()));
    check("busy_vec_nobyp", 64'(busy_n), 64'(exp_vec()));
    @(posedge clk);
    if (!rst_n) clear_model();
    else begin
      for (int k = 0; k < 2; k++) begin
        a = int'(waddr[k*5 +: 5]);
        if (we[k] && a != 0) begin
          m_reg[a] = wdata[k*32 +: 32];
          m_busy[a] = 1'b0;
        end
      end
      if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] a0, a1, r0, r1, ird;
    rst_n = 1'b0;
    clear_model();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    check("reset_busy_vec", 64'(busy_b), 64'h0);
    step();
    rst_n = 1'b1;

    // Reset mid-operation
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd6, 1'b1, 5'd6);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0);
    #1;
    check("pre_reset_x5", 64'(rdata_b[31:0]), 64'hDEADBEEF);
    check("pre_reset_busy6", 64'(busy_b[6]), 64'h1);
    rst_n = 1'b0;
    #1;
    check("async_reset_x5", 64'(rdata_b[31:0]), 64'h0);
    check("async_reset_busy_vec", 64'(busy_b), 64'h0);
    drive(2'b10, 5'd0, 32'h0, 5'd5, 32'h1234, 5'd5, 5'd6, 1'b1, 5'd5);
    #1;
    check("reset_no_bypass_x5", 64'(rdata_b[31:0]), 64'h0);
    step();
    rst_n = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0);
    step();

    // x0 protection
    drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
    #1;
    check("x0_same_cycle", 64'(rdata_b[31:0]), 64'h0);
    step();
    check("x0_next", 64'(rdata_b[31:0]), 64'h0);
    check("x0_busy", 64'(busy_b[0]), 64'h0);

    // Write priority and bypass
    drive(2'b01, 5'd3, 32'h77, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
    step();
    drive(2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 5'd3, 5'd0, 1'b0, 5'd0);
    #1;
    check("prio_bypass_same", 64'(rdata_b[31:0]), 64'h22);
    check("prio_nobypass_old", 64'(rdata_n[31:0]), 64'h77);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
    #1;
    check("prio_bypass_after", 64'(rdata_b[31:0]), 64'h22);
    check("prio_nobypass_after", 64'(rdata_n[31:0]), 64'h22);

    // Scoreboard lifecycle
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd7);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0);
    #1;
    check("sb_busy7", 64'(busy_b[7]), 64'h1);
    check("sb_rbusy7", 64'(rbusy_b[1]), 64'h1);
    drive(2'b10, 5'd0, 32'h0, 5'd7, 32'h55, 5'd0, 5'd7, 1'b0, 5'd0);
    #1;
    check("sb_rbusy7_wb_byp", 64'(rbusy_b[1]), 64'h0);
    check("sb_rbusy7_wb_nobyp", 64'(rbusy_n[1]), 64'h1);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0);
    #1;
    check("sb_busy7_cleared", 64'(busy_b[7]), 64'h0);
    check("sb_x7_data", 64'(rdata_n[63:32]), 64'h55);

    // Simultaneous issue and writeback
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
    step();
    drive(2'b01, 5'd9, 32'hABCD, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    #1;
    check("iss_wb_busy9", 64'(busy_b[9]), 64'h1);
    check("iss_wb_x9", 64'(rdata_n[31:0]), 64'hABCD);
    step();

    // Random stream
    for (int c = 0; c < 2000; c++) begin
      a0  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r0  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      r1  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ird = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      drive(2'($urandom_range(0, 3)), a0, 32'($urandom), a1, 32'($urandom), r0, r1,
            1'($urandom_range(0, 1)), ird);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
